// File: rtl/issue_sched.sv
// issue_sched: three-entry age-ordered issue window with a 64-bit register
// scoreboard. Dispatches the oldest hazard-free entry to each ready unit
// (io, mem, alu, alu2, fpu, fpu2), retires board bits on writeback and
// clears the window on a branch flush.
module issue_sched (
  input  logic         clk,
  input  logic         rstn,
  input  logic [1:0]   in_vld,
  input  logic [68:0]  in_data0,
  input  logic [68:0]  in_data1,
  output logic         in_rdy,
  input  logic         flush,
  input  logic [5:0]   unit_rdy,
  output logic [5:0]   iss_vld,
  output logic [413:0] iss_data,
  input  logic [5:0]   wb_vld,
  input  logic [35:0]  wb_addr,
  output logic         busy
);
  // Allocation order: alu2 before alu and fpu2 before fpu, so an entry
  // allowed on either unit of a pair lands on the second one when it is free.
  localparam logic [17:0] ORDER = {3'd4, 3'd5, 3'd2, 3'd3, 3'd1, 3'd0};

  logic [2:0]  ent_vld;
  logic [68:0] ent_word [3];
  logic [63:0] board;

  logic [63:0] rd_mask [3];
  logic [63:0] wr_mask [3];
  logic [5:0]  ent_mod [3];
  logic [2:0]  is_br;
  logic [2:0]  elig;
  logic [2:0]  taken;
  logic [5:0]  unit_hit;
  logic [1:0]  unit_sel [6];
  logic [2:0]  ku;
  logic [1:0]  cnt;
  logic [2:0]  nxt_vld;
  logic [68:0] nxt_word [3];
  logic [63:0] nxt_board;

  // Registers with r[4:0]==0 (r0 and r32) are never tracked.
  function automatic logic [63:0] reg_bit(input logic [5:0] r);
    logic [63:0] m;
    m = '0;
    if (r[4:0] != 5'd0) m[r] = 1'b1;
    return m;
  endfunction

  assign in_rdy = !((ent_vld[0] & ent_vld[1]) | (ent_vld[0] & ent_vld[2]) |
                    (ent_vld[1] & ent_vld[2]));
  assign busy   = ~in_rdy;

  // Decode register masks, unit mask and branch flag of each window entry.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      rd_mask[i] = reg_bit(ent_word[i][48:43]) | reg_bit(ent_word[i][42:37]);
      wr_mask[i] = reg_bit(ent_word[i][36:31]);
      ent_mod[i] = ent_word[i][5:0];
      is_br[i]   = (ent_word[i][50:49] == 2'b10) && (ent_word[i][54:52] != 3'd0);
    end
  end

  // Eligibility: board-clear and free of hazards against every older entry.
  // Older entries dispatched this same cycle still count, since their board
  // bits only appear next cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      elig[i] = ent_vld[i] && (((rd_mask[i] | wr_mask[i]) & board) == '0);
      for (int unsigned j = 0; j < 3; j++) begin
        if (j < i && ent_vld[j]) begin
          if ((wr_mask[j] & (rd_mask[i] | wr_mask[i])) != '0) elig[i] = 1'b0;
          if ((rd_mask[j] & wr_mask[i]) != '0)                 elig[i] = 1'b0;
          if (is_br[j])                                        elig[i] = 1'b0;
          if (ent_mod[j][0] && ent_mod[i][0])                  elig[i] = 1'b0;
          if (ent_mod[j][1] && ent_mod[i][1])                  elig[i] = 1'b0;
        end
      end
    end
  end

  // Each ready unit takes the oldest eligible, not yet claimed entry.
  always_comb begin
    taken    = '0;
    unit_hit = '0;
    ku       = '0;
    for (int unsigned k = 0; k < 6; k++) unit_sel[k] = 2'd0;
    for (int unsigned n = 0; n < 6; n++) begin
      ku = ORDER[3*n +: 3];
      for (int unsigned i = 0; i < 3; i++) begin
        if (unit_rdy[ku] && !flush && !unit_hit[ku] && !taken[i] &&
            elig[i] && ent_mod[i][ku]) begin
          unit_hit[ku] = 1'b1;
          unit_sel[ku] = 2'(i);
          taken[i]     = 1'b1;
        end
      end
    end
  end

  // Compact surviving entries, then append accepted decode slots in order.
  always_comb begin
    cnt     = 2'd0;
    nxt_vld = '0;
    for (int unsigned i = 0; i < 3; i++) nxt_word[i] = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (ent_vld[i] && !taken[i]) begin
        nxt_vld[cnt]  = 1'b1;
        nxt_word[cnt] = ent_word[i];
        cnt           = cnt + 2'd1;
      end
    end
    if (in_rdy && in_vld[0]) begin
      nxt_vld[cnt]  = 1'b1;
      nxt_word[cnt] = in_data0;
      cnt           = cnt + 2'd1;
    end
    if (in_rdy && in_vld[1]) begin
      nxt_vld[cnt]  = 1'b1;
      nxt_word[cnt] = in_data1;
    end
    if (flush) nxt_vld = '0;
  end

  // Board update: writebacks clear first so a same-cycle dispatch set wins.
  always_comb begin
    nxt_board = board;
    for (int unsigned k = 0; k < 6; k++)
      if (wb_vld[k]) nxt_board[wb_addr[6*k +: 6]] = 1'b0;
    for (int unsigned k = 0; k < 6; k++)
      if (unit_hit[k]) nxt_board = nxt_board | wr_mask[unit_sel[k]];
  end

  // Window, board and registered dispatch outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ent_vld  <= '0;
      board    <= '0;
      iss_vld  <= '0;
      iss_data <= '0;
      for (int unsigned i = 0; i < 3; i++) ent_word[i] <= '0;
    end else begin
      ent_vld <= nxt_vld;
      board   <= nxt_board;
      iss_vld <= unit_hit;
      for (int unsigned i = 0; i < 3; i++) ent_word[i] <= nxt_word[i];
      for (int unsigned k = 0; k < 6; k++)
        if (unit_hit[k]) iss_data[69*k +: 69] <= ent_word[unit_sel[k]];
    end
  end
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: table-driven dual-slot dispatch vectors plus hand-written
// hazard, backpressure, flush and reset sequences. Every dispatch seen on
// iss_vld is matched against an expected-dispatch queue.
`timescale 1ns/1ps
module tb_issue_sched;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [1:0]   in_vld = '0;
  logic [68:0]  in_data0 = '0;
  logic [68:0]  in_data1 = '0;
  logic         in_rdy;
  logic         flush = 1'b0;
  logic [5:0]   unit_rdy = '1;
  logic [5:0]   iss_vld;
  logic [413:0] iss_data;
  logic [5:0]   wb_vld = '0;
  logic [35:0]  wb_addr = '0;
  logic         busy;

  issue_sched dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_data0(in_data0),
    .in_data1(in_data1), .in_rdy(in_rdy), .flush(flush), .unit_rdy(unit_rdy),
    .iss_vld(iss_vld), .iss_data(iss_data), .wb_vld(wb_vld), .wb_addr(wb_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] M_IO  = 6'b000001;
  localparam logic [5:0] M_MEM = 6'b000010;
  localparam logic [5:0] M_ALU = 6'b000100;
  localparam logic [5:0] M_AX  = 6'b001100;
  localparam logic [5:0] M_FX  = 6'b110000;

  typedef struct { int unsigned unit; logic [68:0] word; } exp_t;
  typedef struct {
    logic [5:0] ma; logic [5:0] da; logic [5:0] mb; logic [5:0] db;
    logic [5:0] rdy; logic [5:0] vld; int unsigned ua; int unsigned ub;
    logic [63:0] brd;
  } vec_t;

  exp_t        expq[$];
  vec_t        vt [6];
  int unsigned tests = 0;
  int unsigned fails = 0;

  function automatic logic [68:0] mk(input logic [13:0] pc, input logic [5:0] ope,
                                     input logic [5:0] ds, input logic [5:0] dt,
                                     input logic [5:0] dd, input logic [5:0] mod);
    return {pc, ope, ds, dt, dd, 16'(pc) ^ 16'hA5A5, 5'd3, 4'd5, mod};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned u, input logic [68:0] w);
    exp_t e;
    e.unit = u;
    e.word = w;
    expq.push_back(e);
  endtask

  task automatic send(input logic [1:0] v, input logic [68:0] d0, input logic [68:0] d1);
    in_vld = v; in_data0 = d0; in_data1 = d1;
    step();
    in_vld = '0;
  endtask

  task automatic wb(input int unsigned u, input logic [5:0] a);
    wb_vld[u] = 1'b1;
    wb_addr[6*u +: 6] = a;
    step();
    wb_vld = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_vld = '0; flush = 1'b0; wb_vld = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 12 && expq.size() != 0; n++) step();
    check(name, 64'(expq.size()), 64'd0);
  endtask

  // Scoreboard: match each dispatch to the oldest expected one for that unit.
  always @(negedge clk) begin
    if (rstn) begin
      for (int unsigned k = 0; k < 6; k++) begin
        if (iss_vld[k]) begin
          int unsigned idx;
          logic        found;
          found = 1'b0;
          idx   = 0;
          for (int unsigned q = 0; q < expq.size(); q++)
            if (!found && expq[q].unit == k) begin found = 1'b1; idx = q; end
          tests++;
          if (!found) begin
            fails++;
            $display("FAIL dispatch u%0d: got word %h, none expected", k, iss_data[69*k +: 69]);
          end else begin
            if (iss_data[69*k +: 69] !== expq[idx].word) begin
              fails++;
              $display("FAIL dispatch u%0d: got %h, want %h", k, iss_data[69*k +: 69], expq[idx].word);
            end
            expq.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [68:0] wa, wb_w, c1, c2, c3, c4, br, m1, y, z, x, r, s, t, p, q;

    vt[0] = '{M_AX,  6'd1,  M_AX,  6'd2,  6'h3F,      6'b001100, 3, 2, 64'h6};
    vt[1] = '{M_IO,  6'd3,  M_MEM, 6'd4,  6'h3F,      6'b000011, 0, 1, 64'h18};
    vt[2] = '{M_FX,  6'd33, M_FX,  6'd34, 6'h3F,      6'b110000, 5, 4, 64'h0000_0006_0000_0000};
    vt[3] = '{M_ALU, 6'd1,  M_AX,  6'd2,  6'h3F,      6'b001100, 2, 3, 64'h6};
    vt[4] = '{M_AX,  6'd1,  M_FX,  6'd40, 6'b110111,  6'b100100, 2, 5, 64'h0000_0100_0000_0002};
    vt[5] = '{M_IO,  6'd0,  M_IO,  6'd32, 6'h3F,      6'b000001, 0, 0, 64'h0};

    // Reset state
    do_reset();
    check("rst iss_vld", 64'(iss_vld), 64'd0);
    check("rst iss_data", 64'(iss_data != '0), 64'd0);
    check("rst in_rdy", 64'(in_rdy), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst board", dut.board, 64'd0);

    // Two-slot dispatch vectors from an empty window
    for (int v = 0; v < 6; v++) begin
      do_reset();
      unit_rdy = vt[v].rdy;
      wa   = mk(14'(100 + v), 6'd0, 6'd0, 6'd0, vt[v].da, vt[v].ma);
      wb_w = mk(14'(200 + v), 6'd0, 6'd0, 6'd0, vt[v].db, vt[v].mb);
      push(vt[v].ua, wa);
      push(vt[v].ub, wb_w);
      send(2'b11, wa, wb_w);
      step();
      check($sformatf("vec%0d iss_vld", v), 64'(iss_vld), 64'(vt[v].vld));
      check($sformatf("vec%0d board", v), dut.board, vt[v].brd);
      drain($sformatf("vec%0d drain", v));
    end
    unit_rdy = '1;

    // RAW: consumer waits for writeback, no bypass
    do_reset();
    wa   = mk(14'd300, 6'd0, 6'd0, 6'd0, 6'd5, M_AX);
    wb_w = mk(14'd301, 6'd0, 6'd5, 6'd0, 6'd6, M_AX);
    push(3, wa);
    send(2'b01, wa, '0);
    send(2'b01, wb_w, '0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("raw held", 64'(iss_vld), 64'd0);
    end
    push(3, wb_w);
    wb(3, 6'd5);
    check("raw M+1", 64'(iss_vld), 64'd0);
    step();
    check("raw M+2", 64'(iss_vld), 64'b001000);
    check("raw board", dut.board, 64'h40);
    drain("raw drain");

    // Window full: backpressure until occupancy drops
    do_reset();
    x = mk(14'd400, 6'd0, 6'd0, 6'd0, 6'd9, M_AX);
    push(3, x);
    send(2'b01, x, '0);
    step();
    c1 = mk(14'd401, 6'd0, 6'd9, 6'd0, 6'd10, M_AX);
    c2 = mk(14'd402, 6'd0, 6'd9, 6'd0, 6'd11, M_AX);
    push(3, c1);
    push(2, c2);
    send(2'b11, c1, c2);
    check("full in_rdy", 64'(in_rdy), 64'd0);
    check("full busy", 64'(busy), 64'd1);
    c3 = mk(14'd403, 6'd0, 6'd9, 6'd0, 6'd12, M_AX);
    c4 = mk(14'd404, 6'd0, 6'd0, 6'd0, 6'd0, M_IO);
    in_vld = 2'b11; in_data0 = c3; in_data1 = c4;
    push(3, c3);
    push(0, c4);
    for (int n = 0; n < 3; n++) begin
      step();
      check("hold in_rdy", 64'(in_rdy), 64'd0);
      check("hold iss_vld", 64'(iss_vld), 64'd0);
    end
    wb(3, 6'd9);
    check("full M+1 in_rdy", 64'(in_rdy), 64'd0);
    step();
    check("full M+2 in_rdy", 64'(in_rdy), 64'd1);
    check("full M+2 iss_vld", 64'(iss_vld), 64'b001100);
    step();
    in_vld = '0;
    drain("full drain");

    // Branch blocks younger entries; flush clears window, board kept
    do_reset();
    x = mk(14'd500, 6'd0, 6'd0, 6'd0, 6'd9, M_AX);
    push(3, x);
    send(2'b01, x, '0);
    step();
    br = mk(14'd501, 6'b001010, 6'd9, 6'd0, 6'd0, M_AX);
    m1 = mk(14'd502, 6'd0, 6'd0, 6'd0, 6'd13, M_MEM);
    send(2'b11, br, m1);
    for (int n = 0; n < 3; n++) begin
      step();
      check("branch blocks", 64'(iss_vld), 64'd0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush iss_vld", 64'(iss_vld), 64'd0);
    check("flush in_rdy", 64'(in_rdy), 64'd1);
    check("flush board", dut.board, 64'h200);
    y = mk(14'd510, 6'd0, 6'd0, 6'd0, 6'd20, M_AX);
    z = mk(14'd511, 6'd0, 6'd0, 6'd0, 6'd21, M_AX);
    send(2'b01, y, '0);
    flush = 1'b1; in_vld = 2'b01; in_data0 = z;
    step();
    flush = 1'b0; in_vld = '0;
    check("flush no dispatch", 64'(iss_vld), 64'd0);
    step();
    check("flush drops input", 64'(iss_vld), 64'd0);
    check("flush board kept", dut.board, 64'h200);
    wb(3, 6'd9);
    check("flush wb board", dut.board, 64'd0);

    // mem ordering behind a blocked older mem op
    do_reset();
    x = mk(14'd600, 6'd0, 6'd0, 6'd0, 6'd9, M_AX);
    push(3, x);
    send(2'b01, x, '0);
    step();
    wa   = mk(14'd601, 6'd0, 6'd9, 6'd0, 6'd14, M_MEM);
    wb_w = mk(14'd602, 6'd0, 6'd0, 6'd0, 6'd15, M_MEM);
    push(1, wa);
    push(1, wb_w);
    send(2'b11, wa, wb_w);
    for (int n = 0; n < 3; n++) begin
      step();
      check("mem order held", 64'(iss_vld[1]), 64'd0);
    end
    wb(3, 6'd9);
    check("mem M+1", 64'(iss_vld[1]), 64'd0);
    step();
    check("mem older", 64'(iss_vld[1]), 64'd1);
    step();
    check("mem younger", 64'(iss_vld[1]), 64'd1);
    drain("mem drain");

    // r0/r32 never tracked; same-cycle set and clear keeps the bit
    do_reset();
    p = mk(14'd700, 6'd0, 6'd0, 6'd0, 6'd0, M_AX);
    q = mk(14'd701, 6'd0, 6'd0, 6'd0, 6'd32, M_AX);
    push(3, p);
    push(2, q);
    send(2'b11, p, q);
    step();
    r = mk(14'd702, 6'd0, 6'd0, 6'd32, 6'd0, M_AX);
    push(3, r);
    send(2'b01, r, '0);
    step();
    check("r0 r32 no block", 64'(iss_vld), 64'b001000);
    check("r0 r32 board", dut.board, 64'd0);
    s = mk(14'd710, 6'd0, 6'd0, 6'd0, 6'd7, M_AX);
    push(3, s);
    send(2'b01, s, '0);
    wb(2, 6'd7);
    check("set wins iss_vld", 64'(iss_vld), 64'b001000);
    check("set wins board", dut.board, 64'h80);

    // Reset mid-operation discards window and board
    t = mk(14'd720, 6'd0, 6'd7, 6'd0, 6'd8, M_AX);
    send(2'b01, t, '0);
    step();
    check("pre-reset held", 64'(iss_vld), 64'd0);
    do_reset();
    check("mid reset board", dut.board, 64'd0);
    check("mid reset in_rdy", 64'(in_rdy), 64'd1);
    step();
    step();
    check("mid reset discards", 64'(iss_vld), 64'd0);
    check("final queue", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/issue_sched.md
# issue_sched

Three-entry issue window and scoreboard scheduler between decode and the execution units (io, mem, alu, alu2, fpu, fpu2) of the dual-issue core. It accepts up to two decoded instructions per cycle and tracks register busy state across the 64-entry {fpr,gpr} file. Each cycle it dispatches the oldest hazard-free entry to each free unit, retires scoreboard bits on unit writeback, and flushes on branch misprediction. It owns the wait-stage busy/backpressure signal and the scoreboard update.

## Interface
- No parameters. Unit index k: 0=io, 1=mem, 2=alu, 3=alu2, 4=fpu, 5=fpu2.
- Decoded-instruction word, 69 bits: [68:55] pc, [54:49] ope, [48:43] ds, [42:37] dt, [36:31] dd, [30:15] imm, [14:10] opr, [9:6] ctrl, [5:0] mod (one-hot per unit; alu|alu2 and fpu|fpu2 pairs allowed).
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_vld  in  2  decode slot valid; bit0 is older.
- in_data0, in_data1  in  69  decoded words for slot 0 and slot 1.
- in_rdy  out  1  window accepts both slots this cycle.
- flush  in  1  branch hazard; kill window contents.
- unit_rdy  in  6  unit k can take an instruction this cycle.
- iss_vld  out  6  registered dispatch strobe to unit k.
- iss_data  out  414  registered word for unit k at bits [69k+68:69k].
- wb_vld  in  6  unit k writes back this cycle.
- wb_addr  in  36  6-bit destination of unit k at [6k+5:6k].
- busy  out  1  equals ~in_rdy.

## Operation
- Window: entries 0..2, age-ordered, with 0 oldest. Each entry holds valid plus the 69-bit word.
- Register bit r is tracked only if r[4:0]≠0. r=0 and r=32 are never marked busy.
- Scoreboard: 64-bit board. An entry is board-clear when none of its tracked ds, dt or dd bits are set.
- Eligibility of entry i. All conditions must hold:
  - valid and board-clear;
  - no older unissued valid entry j<i writes a tracked register that i reads or writes (RAW, WAW);
  - no older unissued entry reads a register that i writes (WAR);
  - no older unissued branch, i.e. ope[1:0]=10 and ope[5:3]≠0;
  - io entries stay in order with older io entries, and mem entries stay in order with older mem entries.
- Dispatch:
  - Each unit with unit_rdy=1 takes the oldest eligible entry whose mod includes it.
  - An entry with alu|alu2 goes to alu2 when alu2 is free, otherwise to alu; fpu|fpu2 follows the same rule.
  - An entry is dispatched to at most one unit.
- On dispatch, set board[dd] if dd is tracked and register iss_vld/iss_data for that unit. Undispatched units get iss_vld=0 and hold their iss_data.
- Writeback clears board[wb_addr[k]] for each wb_vld[k]. If a bit is set and cleared in the same cycle, set wins.
- Compaction: remaining entries shift down with order preserved. Accepted slots then append, slot 0 before slot 1; an in_vld=0 slot is not appended.
- in_rdy = (valid entries before dispatch ≤ 1). When in_rdy=0, inputs are ignored and decode holds them.
- flush: next cycle all entries are invalid, no dispatch occurs this cycle (iss_vld=0), and inputs are dropped. Board is untouched because in-flight ops still write back.
- Reset: window empty, board=0, iss_vld=0, iss_data=0. in_rdy=1 and busy=0 from the first cycle after reset.

## Timing
- Instruction accepted at edge N can be dispatched at edge N+1, with iss_vld high during cycle N+1.
- Writeback does not bypass the scoreboard. A consumer of a register written back in cycle M dispatches no earlier than the edge ending cycle M+1.
- Up to 6 dispatches per cycle (one per unit) and up to 2 acceptances per cycle.
- in_rdy and busy are combinational from window occupancy only, and are independent of unit_rdy and flush.
- Reset mid-operation discards everything, including outstanding board bits.

## Test plan
- Reset, then two independent alu ops (dd=1, dd=2) in one cycle → next cycle iss_vld[3]=1 with the older op and iss_vld[2]=1 with the younger; board bits 1 and 2 set.
- RAW: op A dd=5, then op B ds=5 → B held until wb_vld with addr 5 in cycle M; B dispatches at the edge ending M+1.
- Window full: 3 entries, all blocked on board → in_rdy=0 and busy=1. Inputs are held and accepted in the cycle after occupancy drops to 1.
- Branch in entry 0 blocked on board, mem op in entry 1 → mem not dispatched. Assert flush → entries cleared, iss_vld=0, board unchanged.
- Two mem ops, older one with busy ds → younger is not dispatched even with unit_rdy[1]=1. Both dispatch in order once the dependency clears.
- Register 0 and 32 as dd → never block. Same-cycle wb and issue to dd=7 → board[7] stays set.
